// File: rtl/blob_src_streamer_pkg.sv
// Shared constants and types for the blob source streamer: word width,
// FIFO entry layout and pool1 input geometry.
package blob_src_streamer_pkg;

    localparam int unsigned BLOB_DW = 16;

    localparam int unsigned POOL1_W = 24;
    localparam int unsigned POOL1_H = 24;
    localparam int unsigned POOL1_C = 4;

    // Prefetch FIFO entry: end-of-frame flag above the data word
    typedef struct packed {
        logic               eop;
        logic [BLOB_DW-1:0] data;
    } blob_entry_t;

    localparam int unsigned BLOB_ENTRY_W = $bits(blob_entry_t);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } src_state_e;

endpackage

// File: rtl/interlayer_sync_fifo.sv
// Small synchronous FIFO with a combinational head (first-word fall-through)
// and an occupancy count, used between layers and as a prefetch buffer.
module interlayer_sync_fifo #(
    parameter int unsigned AW = 2,
    parameter int unsigned DW = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_ok, rd_ok;

    // Writes into a full FIFO and reads from an empty one are dropped
    always_comb begin
        wr_ok    = wr_en && (cnt_q != CW'(DEPTH));
        rd_ok    = rd_en && (cnt_q != '0);
        wr_ptr_d = wr_ptr_q + AW'(wr_ok);
        rd_ptr_d = rd_ptr_q + AW'(rd_ok);
        cnt_d    = cnt_q + CW'(wr_ok) - CW'(rd_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (wr_ok) begin
                mem_q[wr_ptr_q] <= wr_data;
            end
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;

endmodule

// File: rtl/blob_src_streamer.sv
// Streams a DB_C x DB_H x DB_W feature map from a synchronous-read buffer RAM
// onto the interlayer blob port, prefetching through a small credit-limited FIFO.
module blob_src_streamer
    import blob_src_streamer_pkg::*;
#(
    parameter int unsigned DB_W    = POOL1_W,
    parameter int unsigned DB_H    = POOL1_H,
    parameter int unsigned DB_C    = POOL1_C,
    parameter int unsigned DW      = BLOB_DW,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DW-1:0]     mem_rd_data,
    input  logic              blob_dout_rdy,
    output logic              blob_dout_en,
    output logic              blob_dout_eop,
    output logic [DW-1:0]     blob_dout
);

    localparam int unsigned N          = DB_W * DB_H * DB_C;
    localparam int unsigned CNT_W      = $clog2(N + 1);
    localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;
    localparam int unsigned UW         = FIFO_AW + 2;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

    src_state_e        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              wr_en_q, wr_en_d;
    logic              wr_eop_q, wr_eop_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [DW:0]       fifo_rd_data;
    logic              fifo_empty;
    logic [FIFO_AW:0]  fifo_cnt;
    logic              pop_c;
    logic [UW-1:0]     used_nxt;

    assign pop_c = blob_dout_rdy & ~fifo_empty;

    // Next-state, counters and read issue. The read strobe is registered, so the
    // credit test looks at next cycle's occupancy plus the read landing then.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        rd_cnt_d = rd_cnt_q + CNT_W'(rd_en_q);
        tx_cnt_d = tx_cnt_q + CNT_W'(pop_c);
        wr_en_d  = rd_en_q;
        wr_eop_d = rd_en_q && (rd_cnt_q == LAST);
        used_nxt = UW'(fifo_cnt) + UW'(wr_en_q) - UW'(pop_c);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    base_d   = base_addr;
                    rd_cnt_d = '0;
                    tx_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (pop_c && (tx_cnt_q == LAST)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        rd_en_d   = (state_d == ST_RUN) && (rd_cnt_d < CNT_W'(N))
                    && ((used_nxt + UW'(rd_en_q)) < UW'(FIFO_DEPTH));
        rd_addr_d = rd_en_d ? (base_d + ADDR_W'(rd_cnt_d)) : rd_addr_q;
        busy_d    = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            rd_cnt_q  <= '0;
            tx_cnt_q  <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_eop_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            rd_cnt_q  <= rd_cnt_d;
            tx_cnt_q  <= tx_cnt_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_eop_q  <= wr_eop_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    interlayer_sync_fifo #(
        .AW (FIFO_AW),
        .DW (DW + 1)
    ) u_prefetch_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .wr_en   (wr_en_q),
        .wr_data ({wr_eop_q, mem_rd_data}),
        .rd_en   (pop_c),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

    assign busy          = busy_q;
    assign done          = done_q;
    assign mem_rd_en     = rd_en_q;
    assign mem_rd_addr   = rd_addr_q;
    assign blob_dout_en  = pop_c;
    assign blob_dout_eop = pop_c & fifo_rd_data[DW];
    assign blob_dout     = fifo_rd_data[DW-1:0];

endmodule

// File: tb/tb_blob_src_streamer.sv
// Directed-sequence bench for blob_src_streamer: each frame is compared word by
// word against the RAM contents, with latency, credit and handshake expectations.
module tb_blob_src_streamer;

    localparam int N        = 2304;
    localparam int RAM_SIZE = 4096;
    localparam int LIMIT    = 20000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] base_addr;
    logic        busy;
    logic        done;
    logic        mem_rd_en;
    logic [11:0] mem_rd_addr;
    logic [15:0] mem_rd_data = 16'h0;
    logic        rdy;
    logic        en;
    logic        eop;
    logic [15:0] dout;

    logic [15:0] ram [RAM_SIZE];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Synchronous-read RAM: data one cycle after the strobe
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    end

    blob_src_streamer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .busy          (busy),
        .done          (done),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .blob_dout_rdy (rdy),
        .blob_dout_en  (en),
        .blob_dout_eop (eop),
        .blob_dout     (dout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input int base, input int i);
        return ram[(base + i) % RAM_SIZE];
    endfunction

    // mode 0: rdy always 1; mode 1: random rdy; mode 2: rdy low for 20 cycles, then 1
    task automatic run_frame(input int base, input int mode, input bit extra_start,
                             input int rst_word);
        int c, idx, reads, eop_c;
        bit fin, aborted, exp_done;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 12'(base); rdy = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; c = 1; idx = 0; reads = 0; eop_c = -1; fin = 1'b0; aborted = 1'b0;
        while (!fin && c < LIMIT) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (c > 20);
            endcase
            start = extra_start && (c == 50);
            if (start) base_addr = 12'(base + 123);
            if (rst_word >= 0 && idx == rst_word) begin
                rdy = 1'b1; rst = 1'b0; #1;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_en", 32'(en), 32'd0);
                chk("rst_eop", 32'(eop), 32'd0);
                chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
                chk("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
                chk("rst_dout", 32'(dout), 32'd0);
                @(posedge clk); #1;
                rst = 1'b1; aborted = 1'b1;
                break;
            end
            @(negedge clk);
            if (c == 1) chk("first_rd", 32'(mem_rd_en), 32'd1);
            if (mem_rd_en) begin
                chk("rd_addr", 32'(mem_rd_addr), 32'((base + reads) % RAM_SIZE));
                reads++;
            end
            chk("credit", 32'(reads - idx <= 4), 32'd1);
            exp_done = (eop_c >= 0) && (c == eop_c + 1);
            chk("done", 32'(done), 32'(exp_done));
            chk("busy", 32'(busy), 32'(!exp_done));
            if (mode == 0) chk("en_timing", 32'(en), 32'(c >= 3 && c <= N + 2));
            if (mode == 2 && c <= 20) chk("stall_en", 32'(en), 32'd0);
            if (mode == 2 && c == 20) chk("stall_reads", 32'(reads <= 4), 32'd1);
            if (mode == 2 && c > 20 && idx < N) chk("resume_en", 32'(en), 32'd1);
            if (en) begin
                chk("word_in_frame", 32'(idx < N), 32'd1);
                if (idx < N) begin
                    chk("data", 32'(dout), 32'(exp_word(base, idx)));
                    chk("eop", 32'(eop), 32'(idx == N - 1));
                end
                if (eop) eop_c = c;
                idx++;
            end else begin
                chk("eop_idle", 32'(eop), 32'd0);
            end
            if (exp_done) fin = 1'b1;
            @(posedge clk); #1;
            c++;
        end
        if (rst_word >= 0) begin
            chk("reset_reached", 32'(aborted), 32'd1);
        end else begin
            chk("frame_finished", 32'(fin), 32'd1);
            chk("word_count", 32'(idx), 32'(N));
            rdy = 1'b1;
            @(negedge clk);
            chk("post_busy", 32'(busy), 32'd0);
            chk("post_done", 32'(done), 32'd0);
            chk("post_en", 32'(en), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; base_addr = 12'h0; rdy = 1'b1;
        for (int a = 0; a < RAM_SIZE; a++) ram[a] = 16'(a);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_rd_en", 32'(mem_rd_en), 32'd0);
        chk("reset_rd_addr", 32'(mem_rd_addr), 32'd0);
        chk("reset_en", 32'(en), 32'd0);
        chk("reset_eop", 32'(eop), 32'd0);
        chk("reset_dout", 32'(dout), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        run_frame(0, 0, 1'b0, -1);
        for (int a = 0; a < RAM_SIZE; a++) ram[a] = 16'($urandom);
        run_frame(int'($urandom_range(0, 1000)), 1, 1'b0, -1);
        run_frame(17, 2, 1'b0, -1);
        run_frame(4000, 0, 1'b0, -1);
        run_frame(200, 1, 1'b1, -1);
        run_frame(300, 0, 1'b0, -1);
        run_frame(0, 0, 1'b0, 100);
        run_frame(0, 1, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/blob_src_streamer.md
Name: blob_src_streamer

Overview:
- Transmit end of the interlayer blob protocol (en/rdy/eop, 16-bit words).
- Reads a feature map (DB_C x DB_H x DB_W, channel-major, then row, then column) from an external synchronous-read buffer RAM.
- Streams the map to the first layer's blob_din port, honouring that layer's ready.
- Used as the image source at the head of the network and as a test driver for individual layers.

Parameters:
- DB_W, 24, feature-map width in words.
- DB_H, 24, feature-map height in words.
- DB_C, 4, channel count.
- DW, 16, data word width.
- ADDR_W, 12, buffer RAM address width; must satisfy 2^ADDR_W >= DB_W*DB_H*DB_C.
- FIFO_AW, 2, log2 depth of the internal prefetch FIFO (depth 4).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins one frame.
- base_addr  in  ADDR_W  frame start address; latched on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the eop word is transferred.
- mem_rd_en  out  1  RAM read strobe.
- mem_rd_addr  out  ADDR_W  RAM read address.
- mem_rd_data  in  DW  RAM read data, valid exactly 1 cycle after mem_rd_en.
- blob_dout_rdy  in  1  downstream may accept a word this cycle.
- blob_dout_en  out  1  word transferred this cycle.
- blob_dout_eop  out  1  the transferred word is the last of the frame.
- blob_dout  out  DW  data word.

Behaviour:
- Reset (rst=0, asynchronous):
  - busy, done, mem_rd_en and all counters clear to 0.
  - The FIFO empties; blob_dout_en and blob_dout_eop are 0.
  - mem_rd_addr and blob_dout go to 0.
- Constant: N = DB_W*DB_H*DB_C. Pool1 defaults give N = 2304.
- FSM states:
  - IDLE: start=1 latches base_addr, clears rd_cnt and tx_cnt, and moves to RUN. busy=1 from the next cycle.
  - RUN: issue reads and drain the FIFO. When the word with tx_cnt==N-1 transfers, move to DONE.
  - DONE: one cycle; done=1 and busy=0. Then return to IDLE.
- start is ignored while busy=1 or in DONE.
- Read issue:
  - mem_rd_en=1 in RUN when rd_cnt<N and (fifo_used + inflight) < 2^FIFO_AW.
  - mem_rd_addr = base_addr + rd_cnt, taken modulo 2^ADDR_W, so the address wraps at the RAM top.
  - rd_cnt increments on each issued read.
  - inflight is a 1-bit flag: the read issued last cycle.
  - This credit rule guarantees no FIFO overflow under any rdy pattern.
- FIFO:
  - Writes mem_rd_data the cycle after mem_rd_en. The entry is {eop_flag, data}, where eop_flag = (address index == N-1).
  - blob_dout_en = blob_dout_rdy & ~fifo_empty, combinational, identical to the existing layer output ports.
  - blob_dout_eop = blob_dout_en & head eop_flag.
  - blob_dout is the FIFO head and is valid whenever blob_dout_en=1.
- Ordering and latency:
  - Words are emitted in address order with no drops or duplicates.
  - Accepted start at cycle T:
    - first mem_rd_en at T+1;
    - data written into the FIFO at T+2;
    - first blob_dout_en at T+3 if rdy=1.
  - With rdy held at 1, throughput is 1 word/cycle after fill. The frame ends with eop at T+2+N and done at T+3+N.
- Backpressure:
  - rdy=0 holds blob_dout_en=0.
  - Reads stop once the credit limit is reached.
  - When rdy returns, streaming resumes with the next word.
- Simultaneous events: when a FIFO write and read happen in the same cycle, fifo_used is unchanged.
- Reset mid-frame: the frame is abandoned, and no eop or done is produced.
- Degenerate N=1: the single word carries eop; done follows it.

Decomposition:
- Shared package holds:
  - the blob word width (16);
  - the FIFO entry layout {eop, data} (width DW+1);
  - the pool1 input geometry constants (24, 24, 4).
- One sub-module: reuse the existing interlayer_sync_fifo (aw=FIFO_AW, dw=DW+1) as the prefetch FIFO.
- Counters, credit logic and FSM stay in the top module.

Test Plan:
- Basic frame: RAM[a]=a, base 0, rdy=1, start at T → en first at T+3; 2304 words with values 0..2303; eop only on value 2303; done at T+2307; busy low afterwards.
- Random backpressure: rdy follows a 50% LFSR pattern → words still 0..2303 in order; FIFO never overflows (fifo_used <= 4); one eop; one done.
- Full stall: rdy=0 for 20 cycles after start → at most 4 reads issued, en=0 throughout; on rdy=1, words 0,1,2,3,4... appear on consecutive cycles.
- Address wrap: base 4000, ADDR_W=12 → read addresses 4000..4095, then 0..2207; data matches RAM contents.
- start while busy: a second start pulse mid-frame is ignored → exactly 2304 words and one done; a new start after done produces a second complete frame.
- Async reset mid-frame: drive rst=0 at word 100 → busy, en and done are 0 immediately; after release plus a new start, a full frame is sent beginning with word 0.
